cache_port_arbiter: RTL and testbench

- Shares the single data-side cache port between two pipeline requesters: port 0 (MEM stage, load/store) and port 1 (IF stage, instruction fetch).
- Forwards the granted requester's read/write onto the cache request lines.
- Holds the grant through multi-cycle misses until the cache raises ready, then returns read data and ready to that requester only.
- Keeps per-port saturating stall counters for performance analysis.

---
 rtl/cache_port_arbiter_if.sv | 55 +++++
 rtl/cache_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_port_arbiter_if.sv
// Bundle of the two requester ports, the cache-side request lines and the
// arbiter status outputs. The arbiter connects through the slave modport;
// the environment (pipeline, cache, bench) drives through master.
interface cache_port_arbiter_if #(
  parameter int unsigned CW = 16
);
  // port 0 : MEM stage load/store
  logic          p0_read;
  logic          p0_we;
  logic [31:0]   p0_a;
  logic [31:0]   p0_wd;
  logic [31:0]   p0_rd;
  logic          p0_ready;

  // port 1 : IF stage instruction fetch
  logic          p1_read;
  logic          p1_we;
  logic [31:0]   p1_a;
  logic [31:0]   p1_wd;
  logic [31:0]   p1_rd;
  logic          p1_ready;

  // shared cache port
  logic          c_read;
  logic          c_we;
  logic [31:0]   c_a;
  logic [31:0]   c_wd;
  logic [31:0]   c_rd;
  logic          c_ready;

  // status
  logic [1:0]    grant;
  logic [CW-1:0] p0_wait_cnt;
  logic [CW-1:0] p1_wait_cnt;

  modport slave (
    input  p0_read, p0_we, p0_a, p0_wd,
    output p0_rd, p0_ready,
    input  p1_read, p1_we, p1_a, p1_wd,
    output p1_rd, p1_ready,
    output c_read, c_we, c_a, c_wd,
    input  c_rd, c_ready,
    output grant, p0_wait_cnt, p1_wait_cnt
  );

  modport master (
    output p0_read, p0_we, p0_a, p0_wd,
    input  p0_rd, p0_ready,
    output p1_read, p1_we, p1_a, p1_wd,
    input  p1_rd, p1_ready,
    input  c_read, c_we, c_a, c_wd,
    output c_rd, c_ready,
    input  grant, p0_wait_cnt, p1_wait_cnt
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-requester arbiter for the single data-side cache port.
// Port 0 = MEM stage, port 1 = IF stage. The grant is held across
// multi-cycle misses; zero-latency hits complete without leaving IDLE.
module cache_port_arbiter #(
  parameter bit          RR = 1'b1,
  parameter int unsigned CW = 16
) (
  input logic             clk,
  input logic             reset,
  cache_port_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]         state;
  logic               owner;
  logic               last_served;

  logic [1:0]         rd_req;
  logic [1:0]         wr_req;
  logic [1:0]         req;
  logic [1:0][31:0]   addr;
  logic [1:0][31:0]   wdata;

  logic               sel_port;
  logic               sel_active;
  logic               done;

  logic [1:0]         ready;
  logic [1:0][31:0]   rdata;
  logic [1:0][CW-1:0] wait_cnt;

  logic               fwd_read;
  logic               fwd_we;
  logic [31:0]        fwd_a;
  logic [31:0]        fwd_wd;
  logic [1:0]         fwd_grant;

  // gather the two ports into indexable vectors
  always_comb begin
    rd_req = {bus.p1_read, bus.p0_read};
    wr_req = {bus.p1_we,   bus.p0_we};
    req    = rd_req | wr_req;
    addr   = {bus.p1_a,  bus.p0_a};
    wdata  = {bus.p1_wd, bus.p0_wd};
  end

  // select the served port: registered owner while BUSY, fresh arbitration in IDLE
  always_comb begin
    sel_port = 1'b0;
    if (state == BUSY) begin
      sel_port = owner;
    end else if (req == 2'b11) begin
      sel_port = RR ? ~last_served : 1'b0;
    end else if (req == 2'b10) begin
      sel_port = 1'b1;
    end
    // an owner that dropped its request (or an empty IDLE) leaves nothing selected
    sel_active = req[sel_port];
    done       = sel_active & bus.c_ready;
  end

  // forward the selected port onto the cache lines; read wins over write
  always_comb begin
    fwd_read  = 1'b0;
    fwd_we    = 1'b0;
    fwd_a     = '0;
    fwd_wd    = '0;
    fwd_grant = '0;
    if (!reset && sel_active) begin
      fwd_read            = rd_req[sel_port];
      fwd_we              = wr_req[sel_port] & ~rd_req[sel_port];
      fwd_a               = addr[sel_port];
      fwd_wd              = wdata[sel_port];
      fwd_grant[sel_port] = 1'b1;
    end
  end

  // state, owner and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sel_active && !bus.c_ready) begin
            state <= BUSY;
            owner <= sel_port;
          end
          if (done) begin
            last_served <= sel_port;
          end
        end
        BUSY: begin
          if (!sel_active) begin
            state <= IDLE;
          end else if (done) begin
            state       <= IDLE;
            last_served <= sel_port;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    // per-port ready / read data: ready is high when idle or on this port's completion
    always_comb begin
      ready[g] = 1'b0;
      rdata[g] = '0;
      if (!reset) begin
        ready[g] = ~req[g] | (done & (sel_port == 1'(g)));
        if (done && (sel_port == 1'(g)) && rd_req[g]) begin
          rdata[g] = bus.c_rd;
        end
      end
    end

    // saturating stall counter: counts requesting cycles without ready
    always_ff @(posedge clk) begin
      if (reset) begin
        wait_cnt[g] <= '0;
      end else if (req[g] && !ready[g] && (wait_cnt[g] != '1)) begin
        wait_cnt[g] <= wait_cnt[g] + CW'(1);
      end
    end
  end

  assign bus.c_read      = fwd_read;
  assign bus.c_we        = fwd_we;
  assign bus.c_a         = fwd_a;
  assign bus.c_wd        = fwd_wd;
  assign bus.grant       = fwd_grant;
  assign bus.p0_ready    = ready[0];
  assign bus.p1_ready    = ready[1];
  assign bus.p0_rd       = rdata[0];
  assign bus.p1_rd       = rdata[1];
  assign bus.p0_wait_cnt = wait_cnt[0];
  assign bus.p1_wait_cnt = wait_cnt[1];

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus; directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_cache_port_arbiter;

  localparam int unsigned CW   = 4;
  localparam int          MAXC = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.CW(CW)) bus_rr ();
  cache_port_arbiter_if #(.CW(CW)) bus_fp ();

  cache_port_arbiter #(.RR(1'b1), .CW(CW)) dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
  cache_port_arbiter #(.RR(1'b0), .CW(CW)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

  // stimulus
  logic        rd_i [2];
  logic        we_i [2];
  logic [31:0] a_i  [2];
  logic [31:0] wd_i [2];
  logic [31:0] crd;
  logic        crdy;

  // reference model state per instance (0 = round-robin, 1 = fixed)
  int m_busy [2];
  int m_owner[2];
  int m_last [2];
  int m_cnt  [2][2];
  int nb_busy [2];
  int nb_owner[2];
  int nb_last [2];
  int nb_cnt  [2][2];

  // observed outputs of one instance
  logic        o_cread, o_cwe;
  logic [31:0] o_ca, o_cwd;
  logic [1:0]  o_grant;
  logic        o_ready[2];
  logic [31:0] o_rd[2];
  logic [CW-1:0] o_cnt[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    bus_rr.p0_read = rd_i[0]; bus_fp.p0_read = rd_i[0];
    bus_rr.p0_we   = we_i[0]; bus_fp.p0_we   = we_i[0];
    bus_rr.p0_a    = a_i[0];  bus_fp.p0_a    = a_i[0];
    bus_rr.p0_wd   = wd_i[0]; bus_fp.p0_wd   = wd_i[0];
    bus_rr.p1_read = rd_i[1]; bus_fp.p1_read = rd_i[1];
    bus_rr.p1_we   = we_i[1]; bus_fp.p1_we   = we_i[1];
    bus_rr.p1_a    = a_i[1];  bus_fp.p1_a    = a_i[1];
    bus_rr.p1_wd   = wd_i[1]; bus_fp.p1_wd   = wd_i[1];
    bus_rr.c_rd    = crd;     bus_fp.c_rd    = crd;
    bus_rr.c_ready = crdy;    bus_fp.c_ready = crdy;
  endtask

  task automatic observe(input int k);
    if (k == 0) begin
      o_cread = bus_rr.c_read; o_cwe = bus_rr.c_we; o_ca = bus_rr.c_a; o_cwd = bus_rr.c_wd;
      o_grant = bus_rr.grant;
      o_ready[0] = bus_rr.p0_ready; o_ready[1] = bus_rr.p1_ready;
      o_rd[0] = bus_rr.p0_rd; o_rd[1] = bus_rr.p1_rd;
      o_cnt[0] = bus_rr.p0_wait_cnt; o_cnt[1] = bus_rr.p1_wait_cnt;
    end else begin
      o_cread = bus_fp.c_read; o_cwe = bus_fp.c_we; o_ca = bus_fp.c_a; o_cwd = bus_fp.c_wd;
      o_grant = bus_fp.grant;
      o_ready[0] = bus_fp.p0_ready; o_ready[1] = bus_fp.p1_ready;
      o_rd[0] = bus_fp.p0_rd; o_rd[1] = bus_fp.p1_rd;
      o_cnt[0] = bus_fp.p0_wait_cnt; o_cnt[1] = bus_fp.p1_wait_cnt;
    end
  endtask

  // compare one instance against the model and compute the model's next state
  task automatic model_check(input int k);
    string p;
    int    req[2];
    int    sel;
    bit    act, done;
    int    e_cread, e_cwe, e_grant;
    logic [31:0] e_ca, e_cwd;
    int    e_ready[2];
    logic [31:0] e_rd[2];
    p = (k == 0) ? "rr" : "fp";
    for (int i = 0; i < 2; i++) req[i] = (rd_i[i] || we_i[i]) ? 1 : 0;
    e_cread = 0; e_cwe = 0; e_grant = 0; e_ca = 0; e_cwd = 0;
    e_ready[0] = 0; e_ready[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
    nb_busy[k] = m_busy[k]; nb_owner[k] = m_owner[k]; nb_last[k] = m_last[k];
    for (int i = 0; i < 2; i++) nb_cnt[k][i] = m_cnt[k][i];
    if (reset) begin
      nb_busy[k] = 0; nb_owner[k] = 0; nb_last[k] = 1;
      nb_cnt[k][0] = 0; nb_cnt[k][1] = 0;
    end else begin
      if (m_busy[k] != 0)           sel = m_owner[k];
      else if (req[0] && req[1])    sel = (k == 0) ? 1 - m_last[k] : 0;
      else if (req[1])              sel = 1;
      else                          sel = 0;
      act  = (req[sel] != 0);
      done = act && crdy;
      if (act) begin
        e_cread = rd_i[sel] ? 1 : 0;
        e_cwe   = (we_i[sel] && !rd_i[sel]) ? 1 : 0;
        e_ca    = a_i[sel];
        e_cwd   = wd_i[sel];
        e_grant = 1 << sel;
      end
      for (int i = 0; i < 2; i++) begin
        e_ready[i] = (req[i] == 0 || (done && sel == i)) ? 1 : 0;
        if (done && sel == i && rd_i[i]) e_rd[i] = crd;
        if (req[i] != 0 && e_ready[i] == 0 && m_cnt[k][i] < MAXC) nb_cnt[k][i] = m_cnt[k][i] + 1;
      end
      if (m_busy[k] == 0) begin
        if (act && !crdy) begin nb_busy[k] = 1; nb_owner[k] = sel; end
        if (done) nb_last[k] = sel;
      end else if (!act) begin
        nb_busy[k] = 0;
      end else if (done) begin
        nb_busy[k] = 0; nb_last[k] = sel;
      end
    end
    observe(k);
    check({p, ".c_read"}, 32'(o_cread), 32'(e_cread));
    check({p, ".c_we"},   32'(o_cwe),   32'(e_cwe));
    check({p, ".c_a"},    o_ca,         e_ca);
    check({p, ".c_wd"},   o_cwd,        e_cwd);
    check({p, ".grant"},  32'(o_grant), 32'(e_grant));
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.p%0d_ready", p, i), 32'(o_ready[i]), 32'(e_ready[i]));
      check($sformatf("%s.p%0d_rd", p, i),    o_rd[i],         e_rd[i]);
      check($sformatf("%s.p%0d_wait", p, i),  32'(o_cnt[i]),   32'(m_cnt[k][i]));
    end
  endtask

  // drive this cycle's inputs and compare in mid-cycle
  task automatic settle();
    apply();
    #4;
    model_check(0);
    model_check(1);
  endtask

  // clock edge: commit model state, then step just past the edge
  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = nb_busy[k]; m_owner[k] = nb_owner[k]; m_last[k] = nb_last[k];
      m_cnt[k][0] = nb_cnt[k][0]; m_cnt[k][1] = nb_cnt[k][1];
    end
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      rd_i[i] = 1'b0; we_i[i] = 1'b0; a_i[i] = '0; wd_i[i] = '0;
    end
    crd = '0; crdy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    settle();
    advance();
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 1; m_cnt[k][0] = 0; m_cnt[k][1] = 0;
    end
    idle_inputs();
    reset = 1'b1;
    settle();
    check("rst.grant", 32'(bus_rr.grant), 32'd0);
    check("rst.p0_ready", 32'(bus_rr.p0_ready), 32'd0);
    advance();
    reset = 1'b0;

    // idle after reset
    settle();
    check("idle.grant", 32'(bus_rr.grant), 32'd0);
    check("idle.c_read", 32'(bus_rr.c_read), 32'd0);
    check("idle.p0_ready", 32'(bus_rr.p0_ready), 32'd1);
    check("idle.p1_ready", 32'(bus_rr.p1_ready), 32'd1);
    check("idle.p0_wait", 32'(bus_rr.p0_wait_cnt), 32'd0);
    advance();

    // zero-latency hit
    rd_i[0] = 1'b1; a_i[0] = 32'h40; crdy = 1'b1; crd = 32'h1234_5678;
    settle();
    check("hit.p0_ready", 32'(bus_rr.p0_ready), 32'd1);
    check("hit.p0_rd", bus_rr.p0_rd, 32'h1234_5678);
    check("hit.grant", 32'(bus_rr.grant), 32'd1);
    check("hit.c_a", bus_rr.c_a, 32'h40);
    advance();
    idle_inputs();
    settle();
    check("hit.nobusy_grant", 32'(bus_rr.grant), 32'd0);
    check("hit.p0_wait", 32'(bus_rr.p0_wait_cnt), 32'd0);
    advance();

    // multi-cycle miss on port 0 with port 1 arriving in cycle 2
    do_reset();
    for (int c = 0; c < 6; c++) begin
      rd_i[0] = 1'b1; a_i[0] = 32'h100;
      rd_i[1] = (c >= 2); a_i[1] = 32'h200;
      crdy = (c == 5); crd = 32'hA5A5_0000 + 32'(c);
      settle();
      check($sformatf("miss%0d.grant", c), 32'(bus_rr.grant), 32'd1);
      check($sformatf("miss%0d.c_a", c), bus_rr.c_a, 32'h100);
      check($sformatf("miss%0d.p1_ready", c), 32'(bus_rr.p1_ready), (c >= 2) ? 32'd0 : 32'd1);
      check($sformatf("miss%0d.p0_ready", c), 32'(bus_rr.p0_ready), (c == 5) ? 32'd1 : 32'd0);
      advance();
    end
    rd_i[0] = 1'b0; crdy = 1'b1; crd = 32'h0BAD_F00D;
    settle();
    check("miss.p0_wait", 32'(bus_rr.p0_wait_cnt), 32'd5);
    check("miss.p1_wait", 32'(bus_rr.p1_wait_cnt), 32'd4);
    check("miss.p1_grant", 32'(bus_rr.grant), 32'd2);
    check("miss.p1_rd", bus_rr.p1_rd, 32'h0BAD_F00D);
    advance();

    // both ports hitting every cycle
    do_reset();
    for (int c = 0; c < 4; c++) begin
      rd_i[0] = 1'b1; rd_i[1] = 1'b1; a_i[0] = 32'h10; a_i[1] = 32'h20; crdy = 1'b1;
      settle();
      check($sformatf("tie%0d.rr_grant", c), 32'(bus_rr.grant), (c % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("tie%0d.fp_grant", c), 32'(bus_fp.grant), 32'd1);
      check($sformatf("tie%0d.fp_p1_wait", c), 32'(bus_fp.p1_wait_cnt), 32'(c));
      advance();
    end

    // read and write together on port 1
    do_reset();
    rd_i[1] = 1'b1; we_i[1] = 1'b1; wd_i[1] = 32'hDEAD_BEEF; a_i[1] = 32'h300; crdy = 1'b1;
    settle();
    check("rw.c_read", 32'(bus_rr.c_read), 32'd1);
    check("rw.c_we", 32'(bus_rr.c_we), 32'd0);
    check("rw.grant", 32'(bus_rr.grant), 32'd2);
    advance();

    // reset in the third BUSY cycle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      rd_i[0] = 1'b1; a_i[0] = 32'h500; crdy = 1'b0;
      settle();
      advance();
    end
    reset = 1'b1; crdy = 1'b1; crd = 32'h7777_7777;
    settle();
    check("rstbusy.p0_ready", 32'(bus_rr.p0_ready), 32'd0);
    check("rstbusy.grant", 32'(bus_rr.grant), 32'd0);
    check("rstbusy.c_read", 32'(bus_rr.c_read), 32'd0);
    advance();
    reset = 1'b0;
    idle_inputs();
    settle();
    check("rstbusy.p0_wait", 32'(bus_rr.p0_wait_cnt), 32'd0);
    check("rstbusy.p1_wait", 32'(bus_rr.p1_wait_cnt), 32'd0);
    advance();
    rd_i[1] = 1'b1; a_i[1] = 32'h600; crdy = 1'b1;
    settle();
    check("rstbusy.idle_grant", 32'(bus_rr.grant), 32'd2);
    advance();

    // stall counter saturation
    do_reset();
    for (int c = 0; c < 20; c++) begin
      rd_i[0] = 1'b1; a_i[0] = 32'h700; crdy = 1'b0;
      settle();
      advance();
    end
    crdy = 1'b1;
    settle();
    check("sat.p0_wait", 32'(bus_rr.p0_wait_cnt), 32'(MAXC));
    advance();

    // random traffic
    idle_inputs();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!((rd_i[i] || we_i[i]) && $urandom_range(0, 9) != 0)) begin
          int r;
          r = $urandom_range(0, 4);
          rd_i[i] = (r == 1 || r == 3);
          we_i[i] = (r == 2 || r == 3);
          a_i[i]  = $urandom;
          wd_i[i] = $urandom;
        end
      end
      crdy = ($urandom_range(0, 2) == 0);
      crd  = $urandom;
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
